// File: rtl/cga_vram_sequencer.sv
// cga_vram_sequencer
// Timing master for the CGA display datapath. It runs the 5-bit character
// clock sequence, issues the per-character strobes, and shares the single-port
// VRAM between the video fetch and a CPU req/ack port.
//
// Ports:
//   clk, reset_n            pixel clock, synchronous active-low reset
//   hres_mode, grph_mode    timing / addressing mode selects
//   video_enabled           video fetch enable
//   crtc_addr, row_addr     CRTC memory and row address
//   cpu_req/we/addr/wdata   CPU request (level) and its payload
//   cpu_ack, cpu_rdata      one-cycle completion pulse and read data
//   ram_addr/we/wdata       VRAM address and write port
//   ram_rdata               VRAM read data (one-cycle latency)
//   clk_seq                 character sequence counter
//   crtc_clk_en, vram_read_char, vram_read_att, charrom_read, disp_pipeline
//                           single-cycle character strobes
module cga_vram_sequencer #(
   parameter logic [2:0] CPU_SLOT = 3'd3
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        hres_mode,
   input  logic        grph_mode,
   input  logic        video_enabled,
   input  logic [13:0] crtc_addr,
   input  logic [4:0]  row_addr,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [13:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   output logic        cpu_ack,
   output logic [7:0]  cpu_rdata,
   output logic [13:0] ram_addr,
   output logic        ram_we,
   output logic [7:0]  ram_wdata,
   input  logic [7:0]  ram_rdata,
   output logic [4:0]  clk_seq,
   output logic        crtc_clk_en,
   output logic        vram_read_char,
   output logic        vram_read_att,
   output logic        charrom_read,
   output logic        disp_pipeline
);

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_PEND = 2'd1,
      ARB_ACK  = 2'd2
   } arb_state_t;

   arb_state_t  state_q, state_d;
   logic [4:0]  clk_seq_q, clk_seq_d;
   logic        hres_q, hres_d;
   logic        crtc_clk_en_q, crtc_clk_en_d;
   logic        vram_read_char_q, vram_read_char_d;
   logic        vram_read_att_q, vram_read_att_d;
   logic        charrom_read_q, charrom_read_d;
   logic        disp_pipeline_q, disp_pipeline_d;
   logic [13:0] ram_addr_q, ram_addr_d;
   logic        ram_we_q, ram_we_d;
   logic [7:0]  ram_wdata_q, ram_wdata_d;
   logic        cpu_ack_q, cpu_ack_d;
   logic        rd_sel_q, rd_sel_d;
   logic        cpu_we_q, cpu_we_d;
   logic [13:0] cpu_addr_q, cpu_addr_d;
   logic [7:0]  cpu_wdata_q, cpu_wdata_d;

   logic [4:0]  phase_s;
   logic [4:0]  last_s;
   logic        fetch_phase_s;
   logic        video_slot_s;
   logic        cpu_slot_s;
   logic [13:0] video_addr_s;
   logic        unused_s;

   assign unused_s = ^{crtc_addr[13], row_addr[4:1]};

   // Sequence advance and strobe decode; everything is decoded for the
   // upcoming cycle so the strobes come straight out of flops.
   always_comb begin
      clk_seq_d = clk_seq_q + 5'd1;
      // The mode only changes at the wrap so a character period is never split.
      if (clk_seq_q == 5'd31) begin
         hres_d = hres_mode;
      end else begin
         hres_d = hres_q;
      end
      if (hres_d) begin
         phase_s = {1'b0, clk_seq_d[3:0]};
         last_s  = 5'd15;
      end else begin
         phase_s = clk_seq_d;
         last_s  = 5'd31;
      end
      fetch_phase_s = (phase_s == 5'd0) || (phase_s == 5'd2);
      video_slot_s  = video_enabled && fetch_phase_s;
      // Fetch phases are handed to the CPU when video is off.
      cpu_slot_s    = (clk_seq_d[2:0] == CPU_SLOT) || (!video_enabled && fetch_phase_s);
      if (grph_mode) begin
         video_addr_s = {row_addr[0], crtc_addr[11:0], phase_s[1]};
      end else begin
         video_addr_s = {crtc_addr[12:0], phase_s[1]};
      end
      vram_read_char_d = video_enabled && (phase_s == 5'd1);
      vram_read_att_d  = video_enabled && (phase_s == 5'd3);
      charrom_read_d   = !grph_mode && (phase_s == 5'd4);
      crtc_clk_en_d    = (phase_s == (last_s - 5'd1));
      disp_pipeline_d  = (phase_s == last_s);
   end

   // CPU arbiter next state and VRAM port drive.
   always_comb begin
      state_d     = state_q;
      cpu_we_d    = cpu_we_q;
      cpu_addr_d  = cpu_addr_q;
      cpu_wdata_d = cpu_wdata_q;
      ram_addr_d  = ram_addr_q;
      ram_we_d    = 1'b0;
      ram_wdata_d = ram_wdata_q;
      cpu_ack_d   = 1'b0;
      rd_sel_d    = 1'b0;
      if (video_slot_s) begin
         ram_addr_d = video_addr_s;
      end else begin
         ram_addr_d = ram_addr_q;
      end
      case (state_q)
         ARB_IDLE: begin
            if (cpu_req) begin
               cpu_we_d    = cpu_we;
               cpu_addr_d  = cpu_addr;
               cpu_wdata_d = cpu_wdata;
               state_d     = ARB_PEND;
            end else begin
               state_d = ARB_IDLE;
            end
         end
         ARB_PEND: begin
            // Video and CPU slots never coincide, so no override is needed here.
            if (cpu_slot_s) begin
               ram_addr_d  = cpu_addr_q;
               ram_we_d    = cpu_we_q;
               ram_wdata_d = cpu_wdata_q;
               state_d     = ARB_ACK;
            end else begin
               state_d = ARB_PEND;
            end
         end
         ARB_ACK: begin
            // Ack lands in the cycle the VRAM read data appears.
            cpu_ack_d = 1'b1;
            rd_sel_d  = !cpu_we_q;
            state_d   = ARB_IDLE;
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q          <= ARB_IDLE;
         clk_seq_q        <= 5'd0;
         hres_q           <= 1'b0;
         crtc_clk_en_q    <= 1'b0;
         vram_read_char_q <= 1'b0;
         vram_read_att_q  <= 1'b0;
         charrom_read_q   <= 1'b0;
         disp_pipeline_q  <= 1'b0;
         ram_addr_q       <= 14'd0;
         ram_we_q         <= 1'b0;
         ram_wdata_q      <= 8'd0;
         cpu_ack_q        <= 1'b0;
         rd_sel_q         <= 1'b0;
         cpu_we_q         <= 1'b0;
         cpu_addr_q       <= 14'd0;
         cpu_wdata_q      <= 8'd0;
      end else begin
         state_q          <= state_d;
         clk_seq_q        <= clk_seq_d;
         hres_q           <= hres_d;
         crtc_clk_en_q    <= crtc_clk_en_d;
         vram_read_char_q <= vram_read_char_d;
         vram_read_att_q  <= vram_read_att_d;
         charrom_read_q   <= charrom_read_d;
         disp_pipeline_q  <= disp_pipeline_d;
         ram_addr_q       <= ram_addr_d;
         ram_we_q         <= ram_we_d;
         ram_wdata_q      <= ram_wdata_d;
         cpu_ack_q        <= cpu_ack_d;
         rd_sel_q         <= rd_sel_d;
         cpu_we_q         <= cpu_we_d;
         cpu_addr_q       <= cpu_addr_d;
         cpu_wdata_q      <= cpu_wdata_d;
      end
   end

   assign clk_seq        = clk_seq_q;
   assign crtc_clk_en    = crtc_clk_en_q;
   assign vram_read_char = vram_read_char_q;
   assign vram_read_att  = vram_read_att_q;
   assign charrom_read   = charrom_read_q;
   assign disp_pipeline  = disp_pipeline_q;
   assign ram_addr       = ram_addr_q;
   assign ram_we         = ram_we_q;
   assign ram_wdata      = ram_wdata_q;
   assign cpu_ack        = cpu_ack_q;
   // VRAM data only arrives in the ack cycle, so the read path passes through
   // a registered select; writes and idle cycles return zero.
   assign cpu_rdata      = rd_sel_q ? ram_rdata : 8'd0;

endmodule

// File: tb/tb_cga_vram_sequencer.sv
// Self-checking bench for cga_vram_sequencer: a cycle-level reference model
// plus a VRAM model, compared on every falling edge, and directed scenarios
// with hand-computed literal expectations.
module tb_cga_vram_sequencer;
   localparam int CPU_SLOT = 3;

   logic        clk = 1'b0;
   logic        reset_n, hres_mode, grph_mode, video_enabled;
   logic [13:0] crtc_addr, cpu_addr, ram_addr;
   logic [4:0]  row_addr, clk_seq;
   logic        cpu_req, cpu_we, cpu_ack, ram_we;
   logic [7:0]  cpu_wdata, cpu_rdata, ram_wdata;
   logic [7:0]  ram_rdata = 8'd0;
   logic        crtc_clk_en, vram_read_char, vram_read_att, charrom_read, disp_pipeline;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] mem    [0:16383];
   logic [7:0] shadow [0:16383];

   cga_vram_sequencer #(.CPU_SLOT(3'd3)) dut (
      .clk(clk), .reset_n(reset_n), .hres_mode(hres_mode), .grph_mode(grph_mode),
      .video_enabled(video_enabled), .crtc_addr(crtc_addr), .row_addr(row_addr),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .ram_addr(ram_addr), .ram_we(ram_we),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .clk_seq(clk_seq),
      .crtc_clk_en(crtc_clk_en), .vram_read_char(vram_read_char),
      .vram_read_att(vram_read_att), .charrom_read(charrom_read),
      .disp_pipeline(disp_pipeline)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // VRAM: one-cycle synchronous read, write on ram_we.
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   // Reference model: per cycle, which strobes fire and who owns VRAM.
   int          m_seq = 0;
   bit          m_hres = 0, m_valid = 0, m_pend = 0, m_serving = 0, m_we = 0;
   logic [13:0] m_addr = 14'd0;
   logic [7:0]  m_wdata = 8'd0;
   logic [13:0] e_addr = 14'd0;
   logic [7:0]  e_wdata = 8'd0, e_rdata = 8'd0;
   bit          e_we, e_ack, e_char, e_att, e_crom, e_crtc, e_disp;

   always @(posedge clk) begin
      int p, last, faddr;
      bit fetch, vslot, cslot, pend_pre, serv_pre;
      m_valid = 1;
      if (!reset_n) begin
         m_seq = 0; m_hres = 0; m_pend = 0; m_serving = 0;
         e_addr = 14'd0; e_wdata = 8'd0; e_rdata = 8'd0;
         e_we = 0; e_ack = 0; e_char = 0; e_att = 0; e_crom = 0; e_crtc = 0; e_disp = 0;
      end else begin
         if (m_seq == 31) m_hres = hres_mode;
         m_seq = (m_seq + 1) % 32;
         p     = m_hres ? m_seq % 16 : m_seq;
         last  = m_hres ? 15 : 31;
         fetch = (p == 0) || (p == 2);
         vslot = video_enabled && fetch;
         cslot = ((m_seq % 8) == CPU_SLOT) || (!video_enabled && fetch);
         e_char = video_enabled && (p == 1);
         e_att  = video_enabled && (p == 3);
         e_crom = !grph_mode && (p == 4);
         e_crtc = (p == last - 1);
         e_disp = (p == last);
         pend_pre = m_pend;
         serv_pre = m_serving;
         e_we = 0; e_ack = 0; e_rdata = 8'd0; m_serving = 0;
         if (serv_pre) begin
            e_ack   = 1;
            e_rdata = m_we ? 8'd0 : shadow[m_addr];
         end
         if (vslot) begin
            if (grph_mode) faddr = row_addr[0] * 8192 + (crtc_addr % 4096) * 2 + (p == 2 ? 1 : 0);
            else           faddr = (crtc_addr % 8192) * 2 + (p == 2 ? 1 : 0);
            e_addr = 14'(faddr);
         end
         if (pend_pre && cslot) begin
            e_we = m_we; e_addr = m_addr; e_wdata = m_wdata;
            if (m_we) shadow[m_addr] = m_wdata;
            m_pend = 0; m_serving = 1;
         end
         if (!pend_pre && !serv_pre && cpu_req) begin
            m_pend = 1; m_we = cpu_we; m_addr = cpu_addr; m_wdata = cpu_wdata;
         end
      end
   end

   // Compare every cycle on the falling edge.
   always @(negedge clk) begin
      if (m_valid) begin
         chk("clk_seq", 32'(clk_seq), 32'(m_seq));
         chk("vram_read_char", 32'(vram_read_char), 32'(e_char));
         chk("vram_read_att", 32'(vram_read_att), 32'(e_att));
         chk("charrom_read", 32'(charrom_read), 32'(e_crom));
         chk("crtc_clk_en", 32'(crtc_clk_en), 32'(e_crtc));
         chk("disp_pipeline", 32'(disp_pipeline), 32'(e_disp));
         chk("ram_addr", 32'(ram_addr), 32'(e_addr));
         chk("ram_we", 32'(ram_we), 32'(e_we));
         chk("ram_wdata", 32'(ram_wdata), 32'(e_wdata));
         chk("cpu_ack", 32'(cpu_ack), 32'(e_ack));
         chk("cpu_rdata", 32'(cpu_rdata), 32'(e_rdata));
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic goto_seq(input logic [4:0] v);
      int n = 0;
      while (clk_seq !== v && n < 80) begin
         step();
         n++;
      end
      if (clk_seq !== v) begin
         n_checks++;
         n_errors++;
         $display("FAIL goto_seq: clk_seq %0d never reached %0d", clk_seq, v);
      end
   endtask

   task automatic cpu_xfer(input logic we, input logic [13:0] a, input logic [7:0] d,
                           output logic [7:0] rd, output int lat);
      cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
      lat = 0; rd = 8'd0;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (cpu_ack === 1'b1) begin
            lat = i;
            rd  = cpu_rdata;
            break;
         end
      end
      cpu_req = 1'b0;
      chk("cpu_latency_le_10", 32'((lat >= 1) && (lat <= 10)), 32'd1);
   endtask

   initial begin
      logic [7:0] rd;
      int lat, acks, wes;
      for (int i = 0; i < 16384; i++) begin
         mem[i]    = 8'((i * 7 + 3) & 255);
         shadow[i] = 8'((i * 7 + 3) & 255);
      end
      reset_n = 1'b0; hres_mode = 1'b0; grph_mode = 1'b0; video_enabled = 1'b1;
      crtc_addr = 14'h0123; row_addr = 5'd0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 14'd0; cpu_wdata = 8'd0;
      step(); step(); step();
      chk("reset_seq", 32'(clk_seq), 32'd0);
      chk("reset_ram_addr", 32'(ram_addr), 32'd0);
      chk("reset_ack", 32'(cpu_ack), 32'd0);
      reset_n = 1'b1;

      // Text, low-res fetch pattern.
      goto_seq(5'd31); goto_seq(5'd0);
      chk("text_addr_b0", 32'(ram_addr), 32'h0246);
      step();
      chk("text_char_seq1", 32'(vram_read_char), 32'd1);
      step();
      chk("text_addr_b1", 32'(ram_addr), 32'h0247);
      goto_seq(5'd30);
      chk("text_crtc_en_seq30", 32'(crtc_clk_en), 32'd1);

      // Hi-res requested mid-period takes effect only at the wrap.
      goto_seq(5'd10);
      hres_mode = 1'b1;
      goto_seq(5'd17);
      chk("hres_not_yet_seq17", 32'(vram_read_char), 32'd0);
      goto_seq(5'd0); goto_seq(5'd17);
      chk("hres_char_seq17", 32'(vram_read_char), 32'd1);
      goto_seq(5'd20);
      chk("hres_crom_seq20", 32'(charrom_read), 32'd1);
      goto_seq(5'd31);
      chk("hres_disp_seq31", 32'(disp_pipeline), 32'd1);

      // Graphics, low-res again.
      goto_seq(5'd5);
      hres_mode = 1'b0; grph_mode = 1'b1; row_addr = 5'd1; crtc_addr = 14'h0050;
      goto_seq(5'd0);
      chk("grph_addr_b0", 32'(ram_addr), 32'h20A0);
      step(); step();
      chk("grph_addr_b1", 32'(ram_addr), 32'h20A1);
      goto_seq(5'd4);
      chk("grph_no_crom", 32'(charrom_read), 32'd0);

      // CPU write then read-back with video running.
      goto_seq(5'd5);
      cpu_xfer(1'b1, 14'h1FFF, 8'hA5, rd, lat);
      chk("wr_ack_seq", 32'(clk_seq), 32'd12);
      step();
      chk("ack_one_cycle", 32'(cpu_ack), 32'd0);
      goto_seq(5'd2);
      cpu_xfer(1'b0, 14'h1FFF, 8'h00, rd, lat);
      chk("rd_data_a5", 32'(rd), 32'hA5);
      chk("rd_capture_in_slot_seq", 32'(clk_seq), 32'd12);
      chk("rd_latency_10", 32'(lat), 32'd10);

      // Video off: fetch phases become CPU slots.
      goto_seq(5'd30);
      video_enabled = 1'b0; cpu_we = 1'b0; cpu_addr = 14'h0100; cpu_req = 1'b1;
      step(); step();
      chk("vdis_served_seq0_addr", 32'(ram_addr), 32'h0100);
      step();
      chk("vdis_ack_seq1", 32'(cpu_ack), 32'd1);
      chk("vdis_rdata", 32'(cpu_rdata), 32'h03);
      chk("vdis_no_char", 32'(vram_read_char), 32'd0);
      cpu_req = 1'b0;
      goto_seq(5'd31);

      // Reset while a request is pending discards it.
      video_enabled = 1'b1;
      goto_seq(5'd4);
      cpu_we = 1'b1; cpu_addr = 14'h0200; cpu_wdata = 8'h3C; cpu_req = 1'b1;
      step(); step();
      reset_n = 1'b0; cpu_req = 1'b0;
      step();
      chk("rst_pend_seq", 32'(clk_seq), 32'd0);
      chk("rst_pend_we", 32'(ram_we), 32'd0);
      chk("rst_pend_addr", 32'(ram_addr), 32'd0);
      chk("rst_pend_disp", 32'(disp_pipeline), 32'd0);
      step();
      reset_n = 1'b1;
      acks = 0; wes = 0;
      for (int i = 0; i < 24; i++) begin
         step();
         if (cpu_ack === 1'b1) acks++;
         if (ram_we === 1'b1) wes++;
      end
      chk("rst_discard_acks", 32'(acks), 32'd0);
      chk("rst_discard_writes", 32'(wes), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
